fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the 5-stage pipeline.

---
 rtl/fwd_hazard_unit_if.sv | 43 ++++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Bundle of pipeline-side signals for the forwarding / load-use hazard unit.
//   master : pipeline control (drives operand/dest info, receives selects and stalls)
//   slave  : fwd_hazard_unit
// Signals:
//   reg_src_ID/src_used_ID  source regs of the ID instruction and which slots are read
//   reg_src_EX              source regs of the EX instruction
//   reg_rd_IDEX/memread_IDEX, reg_rd_EXMEM/regwrite_EXMEM, reg_rd_MEMWB/regwrite_MEMWB
//   flush                   branch/jump flush of IF/ID and ID/EX
//   forward_sel             2 bits per slot: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_pc/stall_ifid/bubble_idex, stall_cycles
interface fwd_hazard_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int CNT_W      = 16
) ();
   logic [NUM_SRC*REG_ADDR_W-1:0] reg_src_ID;
   logic [NUM_SRC-1:0]            src_used_ID;
   logic [NUM_SRC*REG_ADDR_W-1:0] reg_src_EX;
   logic [REG_ADDR_W-1:0]         reg_rd_IDEX;
   logic                          memread_IDEX;
   logic [REG_ADDR_W-1:0]         reg_rd_EXMEM;
   logic                          regwrite_EXMEM;
   logic [REG_ADDR_W-1:0]         reg_rd_MEMWB;
   logic                          regwrite_MEMWB;
   logic                          flush;
   logic [2*NUM_SRC-1:0]          forward_sel;
   logic                          stall_pc;
   logic                          stall_ifid;
   logic                          bubble_idex;
   logic [CNT_W-1:0]              stall_cycles;

   modport master (
      output reg_src_ID, src_used_ID, reg_src_EX, reg_rd_IDEX, memread_IDEX,
             reg_rd_EXMEM, regwrite_EXMEM, reg_rd_MEMWB, regwrite_MEMWB, flush,
      input  forward_sel, stall_pc, stall_ifid, bubble_idex, stall_cycles
   );

   modport slave (
      input  reg_src_ID, src_used_ID, reg_src_EX, reg_rd_IDEX, memread_IDEX,
             reg_rd_EXMEM, regwrite_EXMEM, reg_rd_MEMWB, regwrite_MEMWB, flush,
      output forward_sel, stall_pc, stall_ifid, bubble_idex, stall_cycles
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   bus      : fwd_hazard_unit_if.slave carrying operand/dest info in, selects/stalls out
// Forwarding selects are combinational. A load-use hazard stalls PC and IF/ID and
// bubbles ID/EX for LOAD_LAT cycles; stall_cycles counts stalled cycles, saturating.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no stall in progress; load-use hazards are evaluated
// S_STALL | remaining stall cycles of a hazard; cnt_q counts down to 0
module fwd_hazard_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int ZERO_REG_EN = 1,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   fwd_hazard_unit_if.slave   bus
);

   typedef enum logic {S_IDLE, S_STALL} state_t;

   // The hazard cycle itself is the first stall cycle, so S_STALL covers LOAD_LAT-1 more.
   localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic [CNT_W-1:0]   stall_cycles_q;
   logic [CNT_W-1:0]   stall_cycles_d;
   logic [2*NUM_SRC-1:0] fwd_sel;
   logic               dep_id;
   logic               hit;
   logic               stall;

   always_comb begin
      logic [REG_ADDR_W-1:0] src;
      logic                  fwd_ok;
      src     = '0;
      fwd_ok  = 1'b0;
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src    = bus.reg_src_EX[i*REG_ADDR_W +: REG_ADDR_W];
         fwd_ok = !((ZERO_REG_EN != 0) && (src == '0));
         if (fwd_ok && bus.regwrite_EXMEM && (bus.reg_rd_EXMEM == src))
            fwd_sel[2*i +: 2] = 2'b10;
         else if (fwd_ok && bus.regwrite_MEMWB && (bus.reg_rd_MEMWB == src))
            fwd_sel[2*i +: 2] = 2'b01;
      end
      if (rst)
         fwd_sel = '0;
   end

   always_comb begin
      logic [REG_ADDR_W-1:0] src;
      src    = '0;
      dep_id = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src = bus.reg_src_ID[i*REG_ADDR_W +: REG_ADDR_W];
         if (bus.src_used_ID[i] && (src == bus.reg_rd_IDEX) &&
             !((ZERO_REG_EN != 0) && (src == '0)))
            dep_id = 1'b1;
      end
   end

   // Hazards are only looked at in S_IDLE so a repeat during a stall cannot extend it.
   assign hit   = (state_q == S_IDLE) && bus.memread_IDEX && dep_id;
   assign stall = (hit || (state_q == S_STALL)) && !bus.flush && !rst;

   assign stall_cycles_d = (stall && (stall_cycles_q != '1)) ?
                           stall_cycles_q + CNT_W'(1) : stall_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         if (bus.flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (hit && (LOAD_LAT > 1)) begin
                     state_q <= S_STALL;
                     cnt_q   <= CNT_INIT;
                  end
               end
               S_STALL: begin
                  if (cnt_q == 4'd0)
                     state_q <= S_IDLE;
                  else
                     cnt_q <= cnt_q - 4'd1;
               end
               default: begin
                  state_q <= S_IDLE;
                  cnt_q   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign bus.forward_sel  = fwd_sel;
   assign bus.stall_pc     = stall;
   assign bus.stall_ifid   = stall;
   assign bus.bubble_idex  = stall;
   assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: DUT A (LOAD_LAT=1, CNT_W=4) and DUT B (LOAD_LAT=3, CNT_W=16).
module tb_fwd_hazard_unit;

   logic clk;
   logic rst;

   fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .CNT_W(4))  ifa ();
   fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .CNT_W(16)) ifb ();

   fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(4))
      u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_EN(1), .CNT_W(16))
      u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_item_t;

   typedef struct {
      logic [4:0] s0;
      logic [4:0] s1;
      logic [4:0] rd_exmem;
      logic       we_exmem;
      logic [4:0] rd_memwb;
      logic       we_memwb;
      logic [3:0] exp_sel;
   } fwd_vec_t;

   sb_item_t sb_q[$];
   int n_tests;
   int n_fail;

   task automatic push(input string nm, input logic [31:0] v);
      sb_item_t it;
      it.name = nm;
      it.exp  = v;
      sb_q.push_back(it);
   endtask

   task automatic pop_chk(input logic [31:0] act);
      sb_item_t it;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: actual %0h with no expected entry", act);
      end else begin
         it = sb_q.pop_front();
         if (act !== it.exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", it.name, act, it.exp);
         end
      end
   endtask

   function automatic logic [31:0] stl_a();
      return {29'd0, ifa.stall_pc, ifa.stall_ifid, ifa.bubble_idex};
   endfunction

   function automatic logic [31:0] stl_b();
      return {29'd0, ifb.stall_pc, ifb.stall_ifid, ifb.bubble_idex};
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input fwd_vec_t v);
      ifa.reg_src_EX     = {v.s1, v.s0};
      ifb.reg_src_EX     = {v.s1, v.s0};
      ifa.reg_rd_EXMEM   = v.rd_exmem;
      ifb.reg_rd_EXMEM   = v.rd_exmem;
      ifa.regwrite_EXMEM = v.we_exmem;
      ifb.regwrite_EXMEM = v.we_exmem;
      ifa.reg_rd_MEMWB   = v.rd_memwb;
      ifb.reg_rd_MEMWB   = v.rd_memwb;
      ifa.regwrite_MEMWB = v.we_memwb;
      ifb.regwrite_MEMWB = v.we_memwb;
   endtask

   fwd_vec_t vecs[9];

   initial begin
      n_tests = 0;
      n_fail  = 0;

      vecs[0] = '{5'd5,  5'd7,  5'd5,  1'b1, 5'd5,  1'b1, 4'b0010};
      vecs[1] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 4'b0000};
      vecs[2] = '{5'd7,  5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 4'b1000};
      vecs[3] = '{5'd9,  5'd9,  5'd5,  1'b1, 5'd9,  1'b1, 4'b0101};
      vecs[4] = '{5'd9,  5'd3,  5'd9,  1'b0, 5'd9,  1'b1, 4'b0001};
      vecs[5] = '{5'd4,  5'd6,  5'd6,  1'b1, 5'd4,  1'b1, 4'b1001};
      vecs[6] = '{5'd4,  5'd6,  5'd4,  1'b0, 5'd6,  1'b0, 4'b0000};
      vecs[7] = '{5'd31, 5'd31, 5'd31, 1'b1, 5'd2,  1'b1, 4'b1010};
      vecs[8] = '{5'd0,  5'd2,  5'd0,  1'b1, 5'd2,  1'b1, 4'b0100};

      // hazard inputs: ID slot0 reads r3, ID/EX load writes r3
      rst = 1'b1;
      ifa.reg_src_ID  = {5'd0, 5'd3};
      ifb.reg_src_ID  = {5'd0, 5'd3};
      ifa.src_used_ID = 2'b01;
      ifb.src_used_ID = 2'b01;
      ifa.reg_rd_IDEX = 5'd3;
      ifb.reg_rd_IDEX = 5'd3;
      ifa.memread_IDEX = 1'b1;
      ifb.memread_IDEX = 1'b1;
      ifa.flush = 1'b0;
      ifb.flush = 1'b0;
      set_fwd(vecs[0]);

      // reset holds every output low even with a hazard and a forwarding match present
      push("rst_sel_a", 32'd0);
      push("rst_sel_b", 32'd0);
      push("rst_stall_a", 32'd0);
      push("rst_stall_b", 32'd0);
      @(negedge clk);
      pop_chk({28'd0, ifa.forward_sel});
      pop_chk({28'd0, ifb.forward_sel});
      pop_chk(stl_a());
      pop_chk(stl_b());
      next_cyc();
      next_cyc();
      rst = 1'b0;
      ifa.memread_IDEX = 1'b0;
      ifb.memread_IDEX = 1'b0;
      push("rst_cnt_a", 32'd0);
      push("rst_cnt_b", 32'd0);
      @(negedge clk);
      pop_chk({28'd0, ifa.stall_cycles});
      pop_chk({16'd0, ifb.stall_cycles});
      next_cyc();

      // forwarding table
      for (int i = 0; i < 9; i++) begin
         set_fwd(vecs[i]);
         push($sformatf("fwd_a_v%0d", i), {28'd0, vecs[i].exp_sel});
         push($sformatf("fwd_b_v%0d", i), {28'd0, vecs[i].exp_sel});
         @(negedge clk);
         pop_chk({28'd0, ifa.forward_sel});
         pop_chk({28'd0, ifb.forward_sel});
         next_cyc();
      end

      // LOAD_LAT=1: one stall cycle only
      ifa.memread_IDEX = 1'b1;
      push("lat1_c1_a", 32'd7);
      push("lat1_c1_b", 32'd0);
      @(negedge clk);
      pop_chk(stl_a());
      pop_chk(stl_b());
      next_cyc();
      ifa.memread_IDEX = 1'b0;
      push("lat1_c2_a", 32'd0);
      push("lat1_cnt_a", 32'd1);
      @(negedge clk);
      pop_chk(stl_a());
      pop_chk({28'd0, ifa.stall_cycles});
      next_cyc();

      // LOAD_LAT=3: hazard repeated in cycle 2 does not extend the stall
      ifb.memread_IDEX = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) ifb.memread_IDEX = 1'b0;
         push($sformatf("lat3_c%0d_b", c + 1), (c < 3) ? 32'd7 : 32'd0);
         @(negedge clk);
         pop_chk(stl_b());
         next_cyc();
      end
      push("lat3_cnt_b", 32'd3);
      @(negedge clk);
      pop_chk({16'd0, ifb.stall_cycles});
      next_cyc();

      // unused slot and r0 never stall
      ifb.memread_IDEX = 1'b1;
      ifb.src_used_ID  = 2'b00;
      push("unused_b", 32'd0);
      @(negedge clk);
      pop_chk(stl_b());
      next_cyc();
      ifb.src_used_ID = 2'b01;
      ifb.reg_rd_IDEX = 5'd0;
      ifb.reg_src_ID  = {5'd0, 5'd0};
      push("zero_b", 32'd0);
      @(negedge clk);
      pop_chk(stl_b());
      next_cyc();
      ifb.memread_IDEX = 1'b0;
      ifb.reg_rd_IDEX  = 5'd3;
      ifb.reg_src_ID   = {5'd0, 5'd3};

      // flush in the 2nd stall cycle
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      ifb.memread_IDEX = 1'b1;
      push("flush_c1_b", 32'd7);
      @(negedge clk);
      pop_chk(stl_b());
      next_cyc();
      ifb.memread_IDEX = 1'b0;
      ifb.flush = 1'b1;
      push("flush_c2_b", 32'd0);
      @(negedge clk);
      pop_chk(stl_b());
      next_cyc();
      ifb.flush = 1'b0;
      push("flush_c3_b", 32'd0);
      @(negedge clk);
      pop_chk(stl_b());
      next_cyc();
      push("flush_c4_b", 32'd0);
      push("flush_cnt_b", 32'd1);
      @(negedge clk);
      pop_chk(stl_b());
      pop_chk({16'd0, ifb.stall_cycles});
      next_cyc();

      // reset in the middle of a stall
      ifb.memread_IDEX = 1'b1;
      push("rstmid_c1_b", 32'd7);
      @(negedge clk);
      pop_chk(stl_b());
      next_cyc();
      ifb.memread_IDEX = 1'b0;
      rst = 1'b1;
      push("rstmid_c2_b", 32'd0);
      push("rstmid_cnt_pre_b", 32'd2);
      @(negedge clk);
      pop_chk(stl_b());
      pop_chk({16'd0, ifb.stall_cycles});
      next_cyc();
      rst = 1'b0;
      push("rstmid_c3_b", 32'd0);
      push("rstmid_cnt_b", 32'd0);
      @(negedge clk);
      pop_chk(stl_b());
      pop_chk({16'd0, ifb.stall_cycles});
      next_cyc();

      // CNT_W=4 saturates at 15 after 20 stall cycles
      ifa.memread_IDEX = 1'b1;
      for (int k = 0; k < 20; k++) begin
         push($sformatf("sat_stall_a_k%0d", k), 32'd7);
         push($sformatf("sat_cnt_a_k%0d", k), (k > 15) ? 32'd15 : k);
         @(negedge clk);
         pop_chk(stl_a());
         pop_chk({28'd0, ifa.stall_cycles});
         next_cyc();
      end
      ifa.memread_IDEX = 1'b0;
      push("sat_cnt_a_end", 32'd15);
      @(negedge clk);
      pop_chk({28'd0, ifa.stall_cycles});

      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: actual %0d entries required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
